renkon_ctrl_img: RTL and testbench
==================================

// Module: renkon_ctrl_img
// PURPOSE
//  Sequencer/arbiter for the single-port image buffer (renkon_mem_img). Shares the port between
//  host write requester and an internal window-scan reader feeding the convolution datapath.
//  Emits raster-ordered FxF window pixel stream with valid/first/last flags aligned to read_data.
// PARAMETERS
//  IMGSIZE  from renkon.vh  image memory address width (words = 2**IMGSIZE)
//  DWIDTH   from renkon.vh  pixel data width, signed
//  SWIDTH   8               width of image-side / filter-side config inputs
// PORTS
//  clk          in   1        clock
//  rst          in   1        asynchronous reset, active-high
//  host_req     in   1        host requests one write this cycle
//  host_addr    in   IMGSIZE  host write address
//  host_wdata   in   DWIDTH   host write data (signed)
//  host_gnt     out  1        write accepted this cycle (combinational)
//  start        in   1        begin scan (pulse)
//  img_size     in   SWIDTH   image side W (square image)
//  fil_size     in   SWIDTH   filter side F
//  stall        in   1        downstream hold (only with RENKON_CTRL_IMG_STALL_EN)
//  mem_we       out  1        to buffer write enable
//  mem_addr     out  IMGSIZE  to buffer address
//  write_data   out  DWIDTH   to buffer write data
//  pix_valid    out  1        buffer read_data is a scan pixel this cycle
//  pix_first    out  1        with pix_valid: first pixel of a window
//  pix_last     out  1        with pix_valid: last pixel of a window
//  busy         out  1        scan in progress
//  done         out  1        one-cycle pulse at scan completion
//  cfg_err      out  1        sticky: last start had F==0 or F>W; cleared by next start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0. Reset mid-scan aborts, no done pulse.
//  FSM IDLE->SCAN on start (F in 1..W, W,F latched); IDLE->DONE on start with bad cfg (cfg_err=1).
//  SCAN->DRAIN after last address issued; DRAIN->DONE when last pix_valid out; DONE->IDLE (done=1).
//  start while not IDLE: ignored. Config inputs only sampled on accepted start.
//  Arbitration: host_gnt = host_req & IDLE & ~start; start wins same-cycle tie, host retries.
//  host_gnt=1 -> mem_we=1, mem_addr=host_addr, write_data=host_wdata same cycle. Else mem_we=0.
//  Scan order: oy 0..W-F, ox 0..W-F, fy 0..F-1, fx 0..F-1 (fx fastest);
//  addr = (oy+fy)*W + ox+fx, built incrementally (row-base adders, no multiplier), mod 2**IMGSIZE.
//  One address per cycle in SCAN; total reads (W-F+1)^2 * F^2.
//  Latency: buffer registers address, so pix_valid/pix_first/pix_last are address-issue flags
//  delayed 1 cycle; aligned with buffer read_data.
//  W*W > 2**IMGSIZE is caller error; addresses wrap, no flag.
// CONFIGURATION
//  RENKON_CTRL_IMG_STALL_EN defined: stall=1 in SCAN holds counters and mem_addr; pix_valid
//   for held cycle is 0 (no duplicate pixel); DRAIN/DONE unaffected. Host still blocked.
//  Not defined: stall port absent; scan never pauses.
// STRUCTURE
//  renkon.vh: IMGSIZE, DWIDTH, SWIDTH, state encodings IMG_IDLE/IMG_SCAN/IMG_DRAIN/IMG_DONE.
//  Sub-module renkon_ctrl_img_addr: nested fx/fy/ox/oy counters + incremental address,
//   outputs addr, first, last, final; inputs en, init, W, F.
// TESTING
//  W=4,F=3 start -> 36 pix_valid; addrs 0,1,2,4,5,6,8,9,10 then 1,2,3,5,6,7,9,10,11; done after 36th.
//  Host write addr 5 data -3 in IDLE -> host_gnt=1, mem_we=1; later scan pixel at addr 5 reads -3.
//  host_req held through W=4,F=3 scan -> host_gnt 0 until IDLE, then 1; same-cycle start+req -> gnt=0.
//  W=F=2 -> 4 reads addrs 0,1,2,3, pix_first on 0, pix_last on 3; F=5,W=4 or F=0 -> no reads, done next+1, cfg_err=1.
//  rst asserted mid-scan (cycle 10) -> all outputs 0 immediately, no done; new start runs full 36 reads.
//  STALL_EN: stall 3 cycles at read 7 -> mem_addr held, pix_valid gaps, address sequence unchanged.

Source files
------------

// File: rtl/renkon_ctrl_img_pkg.sv
// Shared types and sizes for the image-buffer sequencer.
// IMGSIZE: image memory address width, DWIDTH: signed pixel width,
// SWIDTH: width of the image-side / filter-side configuration inputs.
package renkon_ctrl_img_pkg;

  localparam int IMGSIZE = 8;
  localparam int DWIDTH  = 16;
  localparam int SWIDTH  = 8;

  typedef enum logic [1:0] {
    IMG_IDLE  = 2'd0,
    IMG_SCAN  = 2'd1,
    IMG_DRAIN = 2'd2,
    IMG_DONE  = 2'd3
  } img_state_t;

  // A window of side f fits a w-by-w image only for 1 <= f <= w.
  function automatic logic cfg_ok(input logic [SWIDTH-1:0] w, input logic [SWIDTH-1:0] f);
    return (f != '0) && (f <= w);
  endfunction

endpackage

// File: rtl/renkon_ctrl_img_addr.sv
// Window-scan address generator: nested fx/fy/ox/oy counters with an
// incrementally built buffer address (row-base adders, no multiplier).
// Order is oy, ox, fy, fx with fx fastest; addresses wrap mod 2**IMGSIZE.
module renkon_ctrl_img_addr
  import renkon_ctrl_img_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               init,
  input  logic [SWIDTH-1:0]  img_w,
  input  logic [SWIDTH-1:0]  fil_f,
  output logic [IMGSIZE-1:0] addr,
  output logic               first,
  output logic               last,
  output logic               final_pix
);

  localparam logic [SWIDTH-1:0]  S_ONE = SWIDTH'(1);
  localparam logic [IMGSIZE-1:0] A_ONE = IMGSIZE'(1);

  logic [SWIDTH-1:0]  w_r;
  logic [SWIDTH-1:0]  f_r;
  logic [SWIDTH-1:0]  fx;
  logic [SWIDTH-1:0]  fy;
  logic [SWIDTH-1:0]  ox;
  logic [SWIDTH-1:0]  oy;
  // line_base = oy*W, win_base = oy*W+ox, row_base = (oy+fy)*W+ox
  logic [IMGSIZE-1:0] line_base;
  logic [IMGSIZE-1:0] win_base;
  logic [IMGSIZE-1:0] row_base;
  logic [IMGSIZE-1:0] w_step;

  logic fx_end;
  logic fy_end;
  logic ox_end;
  logic oy_end;

  assign w_step = IMGSIZE'(w_r);
  assign fx_end = (fx == f_r - S_ONE);
  assign fy_end = (fy == f_r - S_ONE);
  assign ox_end = (ox == w_r - f_r);
  assign oy_end = (oy == w_r - f_r);

  assign first     = (fx == '0) && (fy == '0);
  assign last      = fx_end && fy_end;
  assign final_pix = last && ox_end && oy_end;

  // Advance the innermost counter that has not wrapped and derive the next address from the matching base.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_r       <= '0;
      f_r       <= '0;
      fx        <= '0;
      fy        <= '0;
      ox        <= '0;
      oy        <= '0;
      line_base <= '0;
      win_base  <= '0;
      row_base  <= '0;
      addr      <= '0;
    end else if (init) begin
      w_r       <= img_w;
      f_r       <= fil_f;
      fx        <= '0;
      fy        <= '0;
      ox        <= '0;
      oy        <= '0;
      line_base <= '0;
      win_base  <= '0;
      row_base  <= '0;
      addr      <= '0;
    end else if (en) begin
      if (!fx_end) begin
        fx   <= fx + S_ONE;
        addr <= addr + A_ONE;
      end else begin
        fx <= '0;
        if (!fy_end) begin
          fy       <= fy + S_ONE;
          row_base <= row_base + w_step;
          addr     <= row_base + w_step;
        end else begin
          fy <= '0;
          if (!ox_end) begin
            ox       <= ox + S_ONE;
            win_base <= win_base + A_ONE;
            row_base <= win_base + A_ONE;
            addr     <= win_base + A_ONE;
          end else begin
            // Wraps harmlessly after the final window; the sequencer stops issuing.
            ox        <= '0;
            oy        <= oy + S_ONE;
            line_base <= line_base + w_step;
            win_base  <= line_base + w_step;
            row_base  <= line_base + w_step;
            addr      <= line_base + w_step;
          end
        end
      end
    end
  end

endmodule

// File: rtl/renkon_ctrl_img.sv
// Sequencer/arbiter for the single-port image buffer. Shares the port
// between host writes and the internal FxF window-scan reader, and flags
// the read stream (valid/first/last) one cycle after address issue so the
// flags line up with the buffer's registered read data.
// Optional feature macro: RENKON_CTRL_IMG_STALL_EN adds the stall input,
// which freezes the scan in SCAN without producing duplicate pixels.
module renkon_ctrl_img
  import renkon_ctrl_img_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     host_req,
  input  logic [IMGSIZE-1:0]       host_addr,
  input  logic signed [DWIDTH-1:0] host_wdata,
  output logic                     host_gnt,
  input  logic                     start,
  input  logic [SWIDTH-1:0]        img_size,
  input  logic [SWIDTH-1:0]        fil_size,
`ifdef RENKON_CTRL_IMG_STALL_EN
  input  logic                     stall,
`endif
  output logic                     mem_we,
  output logic [IMGSIZE-1:0]       mem_addr,
  output logic signed [DWIDTH-1:0] write_data,
  output logic                     pix_valid,
  output logic                     pix_first,
  output logic                     pix_last,
  output logic                     busy,
  output logic                     done,
  output logic                     cfg_err
);

  img_state_t         state;
  logic               hold;
  logic               scan_en;
  logic               scan_init;
  logic               start_ok;
  logic [IMGSIZE-1:0] scan_addr;
  logic               a_first;
  logic               a_last;
  logic               a_final;

`ifdef RENKON_CTRL_IMG_STALL_EN
  assign hold = stall;
`else
  assign hold = 1'b0;
`endif

  assign start_ok  = cfg_ok(img_size, fil_size);
  assign scan_en   = (state == IMG_SCAN) && !hold;
  assign scan_init = start && (state == IMG_IDLE) && start_ok;

  // Host only owns the port in IDLE; a same-cycle start takes priority.
  assign host_gnt   = host_req && (state == IMG_IDLE) && !start;
  assign mem_we     = host_gnt;
  assign write_data = host_gnt ? host_wdata : '0;
  assign mem_addr   = (state == IMG_SCAN) ? scan_addr :
                      (host_gnt ? host_addr : '0);

  renkon_ctrl_img_addr u_addr (
    .clk       (clk),
    .rst       (rst),
    .en        (scan_en),
    .init      (scan_init),
    .img_w     (img_size),
    .fil_f     (fil_size),
    .addr      (scan_addr),
    .first     (a_first),
    .last      (a_last),
    .final_pix (a_final)
  );

  // Scan state machine with registered status and one-cycle-delayed pixel flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IMG_IDLE;
      pix_valid <= 1'b0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      pix_valid <= scan_en;
      pix_first <= scan_en && a_first;
      pix_last  <= scan_en && a_last;
      done      <= 1'b0;
      case (state)
        IMG_IDLE: begin
          if (start) begin
            if (start_ok) begin
              state   <= IMG_SCAN;
              busy    <= 1'b1;
              cfg_err <= 1'b0;
            end else begin
              state   <= IMG_DONE;
              done    <= 1'b1;
              cfg_err <= 1'b1;
            end
          end
        end
        IMG_SCAN: begin
          if (scan_en && a_final) begin
            state <= IMG_DRAIN;
          end
        end
        IMG_DRAIN: begin
          // The final pixel is on the read port this cycle.
          state <= IMG_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        IMG_DONE: begin
          state <= IMG_IDLE;
        end
        default: begin
          state <= IMG_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_renkon_ctrl_img.sv
// Bench for renkon_ctrl_img: a behavioural image buffer, a window-order
// reference model and one per-cycle compare process, plus directed tests.
module tb_renkon_ctrl_img;
  import renkon_ctrl_img_pkg::*;

  localparam int AW   = IMGSIZE;
  localparam int DW   = DWIDTH;
  localparam int MEMW = 1 << IMGSIZE;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 host_req;
  logic [AW-1:0]        host_addr;
  logic signed [DW-1:0] host_wdata;
  logic                 host_gnt;
  logic                 start;
  logic [SWIDTH-1:0]    img_size;
  logic [SWIDTH-1:0]    fil_size;
`ifdef RENKON_CTRL_IMG_STALL_EN
  logic                 stall;
`endif
  logic                 mem_we;
  logic [AW-1:0]        mem_addr;
  logic signed [DW-1:0] write_data;
  logic                 pix_valid;
  logic                 pix_first;
  logic                 pix_last;
  logic                 busy;
  logic                 done;
  logic                 cfg_err;

  renkon_ctrl_img dut (
    .clk        (clk),
    .rst        (rst),
    .host_req   (host_req),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .start      (start),
    .img_size   (img_size),
    .fil_size   (fil_size),
`ifdef RENKON_CTRL_IMG_STALL_EN
    .stall      (stall),
`endif
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .pix_valid  (pix_valid),
    .pix_first  (pix_first),
    .pix_last   (pix_last),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking infrastructure ----------------
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input longint act, input longint want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  // ---------------- image buffer (registered read) ----------------
  logic signed [DW-1:0] bufmem [MEMW];
  bit                   bufwr  [MEMW];
  logic signed [DW-1:0] read_data;

  function automatic logic signed [DW-1:0] init_val(input int a);
    return DW'(a * 7 - 300);
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      bufmem[mem_addr] <= write_data;
      bufwr[mem_addr]  <= 1'b1;
    end
    read_data <= bufwr[mem_addr] ? bufmem[mem_addr] : init_val(int'(mem_addr));
  end

  // ---------------- reference model ----------------
  typedef struct {
    int addr;
    bit first;
    bit last;
  } pix_t;

  pix_t                 exp_q[$];
  logic signed [DW-1:0] model_mem [MEMW];
  int                   pix_cnt = 0;
  bit                   done_due = 1'b0;
  bit                   cfg_done_due = 1'b0;
  int                   prev_addr = 0;

  // Expected read stream of a full scan, straight from the window definition.
  task automatic gen_scan(input int w, input int f);
    for (int oy = 0; oy <= w - f; oy++)
      for (int ox = 0; ox <= w - f; ox++)
        for (int fy = 0; fy < f; fy++)
          for (int fx = 0; fx < f; fx++) begin
            pix_t p;
            p.addr  = ((oy + fy) * w + ox + fx) % MEMW;
            p.first = (fx == 0) && (fy == 0);
            p.last  = (fx == f - 1) && (fy == f - 1);
            exp_q.push_back(p);
          end
  endtask

  // Per-cycle compare: done timing and every pixel against the model.
  always @(negedge clk) begin : cmp
    pix_t p;
    if (!rst) begin
      chk("done", done, longint'(done_due | cfg_done_due));
      done_due = 1'b0;
      if (pix_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_pix", 1, 0);
        end else begin
          p = exp_q.pop_front();
          pix_cnt++;
          chk("pix_addr", prev_addr, p.addr);
          chk("pix_first", pix_first, longint'(p.first));
          chk("pix_last", pix_last, longint'(p.last));
          chk("pix_data", read_data, model_mem[p.addr]);
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
    end
    prev_addr = int'(mem_addr);
  end

  // ---------------- stimulus helpers ----------------
  task automatic start_scan(input int w, input int f);
    start    = 1'b1;
    img_size = SWIDTH'(w);
    fil_size = SWIDTH'(f);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < budget);
    if (done !== 1'b1) chk({name, "_timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pix_valid"}, pix_valid, 0);
    chk({tag, "_pix_first"}, pix_first, 0);
    chk({tag, "_pix_last"}, pix_last, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_host_gnt"}, host_gnt, 0);
    chk({tag, "_write_data"}, write_data, 0);
  endtask

  int pin_a [18] = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 1, 2, 3, 5, 6, 7, 9, 10, 11};

  initial begin
    rst        = 1'b1;
    host_req   = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    start      = 1'b0;
    img_size   = '0;
    fil_size   = '0;
`ifdef RENKON_CTRL_IMG_STALL_EN
    stall      = 1'b0;
`endif
    for (int i = 0; i < MEMW; i++) model_mem[i] = init_val(i);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Pin the model against hand-computed W=4,F=3 addresses
    gen_scan(4, 3);
    chk("model_len_w4f3", exp_q.size(), 36);
    for (int i = 0; i < 18; i++) chk("model_addr_w4f3", exp_q[i].addr, pin_a[i]);
    chk("model_final_addr", exp_q[35].addr, 15);
    exp_q.delete();
    gen_scan(2, 2);
    for (int i = 0; i < 4; i++) chk("model_addr_w2f2", exp_q[i].addr, i);
    chk("model_first_w2f2", exp_q[0].first, 1);
    chk("model_last_w2f2", exp_q[3].last, 1);
    exp_q.delete();

    // Host write in IDLE: addr 5 <= -3
    host_req   = 1'b1;
    host_addr  = AW'(5);
    host_wdata = -DW'(3);
    #1;
    chk("hw_gnt", host_gnt, 1);
    chk("hw_we", mem_we, 1);
    chk("hw_addr", mem_addr, 5);
    chk("hw_data", write_data, -3);
    model_mem[5] = -DW'(3);
    @(posedge clk); #1;
    host_req = 1'b0;
    #1;
    chk("hw_we_off", mem_we, 0);

    // Full W=4,F=3 scan; addr 5 must now read back -3
    pix_cnt = 0;
    gen_scan(4, 3);
    start_scan(4, 3);
    chk("scan_busy", busy, 1);
    wait_done("w4f3", 200);
    chk("w4f3_count", pix_cnt, 36);
    chk("w4f3_left", exp_q.size(), 0);
    chk("w4f3_busy_end", busy, 0);

    // Host request held across a scan; start wins the tie
    pix_cnt    = 0;
    gen_scan(4, 3);
    host_req   = 1'b1;
    host_addr  = AW'(200);
    host_wdata = DW'(77);
    model_mem[200] = DW'(77);
    start      = 1'b1;
    img_size   = SWIDTH'(4);
    fil_size   = SWIDTH'(3);
    #1;
    chk("tie_gnt", host_gnt, 0);
    chk("tie_we", mem_we, 0);
    @(posedge clk); #1;
    start = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        chk("held_gnt", host_gnt, 0);
        n++;
      end while (done !== 1'b1 && n < 200);
      if (done !== 1'b1) chk("held_timeout", 0, 1);
    end
    @(negedge clk);
    chk("held_gnt_idle", host_gnt, 1);
    chk("held_we_idle", mem_we, 1);
    chk("held_addr_idle", mem_addr, 200);
    @(posedge clk); #1;
    host_req = 1'b0;
    chk("held_count", pix_cnt, 36);

    // Bad configurations: F>W then F=0
    pix_cnt = 0;
    start_scan(4, 5);
    cfg_done_due = 1'b1;
    @(negedge clk);
    chk("bad_f5_cfg_err", cfg_err, 1);
    chk("bad_f5_busy", busy, 0);
    @(posedge clk); #1;
    cfg_done_due = 1'b0;
    repeat (3) @(negedge clk);
    chk("bad_f5_no_pix", pix_cnt, 0);
    @(posedge clk); #1;
    start_scan(4, 0);
    cfg_done_due = 1'b1;
    @(negedge clk);
    chk("bad_f0_cfg_err", cfg_err, 1);
    @(posedge clk); #1;
    cfg_done_due = 1'b0;
    repeat (3) @(negedge clk);
    chk("bad_f0_no_pix", pix_cnt, 0);
    chk("bad_f0_cfg_err_sticky", cfg_err, 1);
    @(posedge clk); #1;

    // W=F=2: single window, clears cfg_err
    gen_scan(2, 2);
    start_scan(2, 2);
    chk("w2f2_cfg_err_clr", cfg_err, 0);
    wait_done("w2f2", 50);
    chk("w2f2_count", pix_cnt, 4);

    // Reset in the middle of a scan
    pix_cnt = 0;
    gen_scan(4, 3);
    start_scan(4, 3);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    pix_cnt = 0;
    gen_scan(4, 3);
    start_scan(4, 3);
    wait_done("after_rst", 200);
    chk("after_rst_count", pix_cnt, 36);

`ifdef RENKON_CTRL_IMG_STALL_EN
    // Stall three cycles while the 7th read is being issued
    pix_cnt = 0;
    gen_scan(4, 3);
    start_scan(4, 3);
    repeat (6) @(posedge clk);
    #1;
    stall = 1'b1;
    #1;
    chk("stall_addr", mem_addr, 8);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_addr_held", mem_addr, 8);
      if (k > 0) chk("stall_pix_gap", pix_valid, 0);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    @(negedge clk);
    chk("stall_pix_gap_last", pix_valid, 0);
    chk("stall_addr_release", mem_addr, 8);
    @(posedge clk); #1;
    wait_done("stall", 200);
    chk("stall_count", pix_cnt, 36);
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
